// File: rtl/sd4_pkg.sv
// Shared types and constants for the SD4 partial-product generator.
// Optional build macro: SD4_ZERO_SKIP_EN (used by sd4_pp_generator).
package sd4_pkg;

   localparam int A_W_DEF  = 8;
   localparam int B_W_DEF  = 16;
   localparam int PP_W_DEF = 16;
   localparam int NUM_PP   = B_W_DEF / 2 + 1;
   localparam int DIGIT_W  = 3;
   localparam int IDX_W    = 4;

   // Radix-4 signed digit: value = (neg ? -1 : 1) * (two ? 2 : one ? 1 : 0)
   typedef struct packed {
      logic neg;
      logic one;
      logic two;
   } digit_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GEN  = 2'd1,
      HOLD = 2'd2
   } state_t;

   function automatic logic digit_nz(digit_t d);
      return d.one | d.two;
   endfunction

endpackage

// File: rtl/sd4_pp_generator_if.sv
// Operand/result handshake bundle between the operand source, the
// partial-product generator and the downstream adder tree.
interface sd4_pp_generator_if #(
   parameter int A_W  = 8,
   parameter int B_W  = 16,
   parameter int PP_W = 16
);
   logic            in_valid;
   logic            in_ready;
   logic [A_W-1:0]  in_a;
   logic [B_W-1:0]  in_b;
   logic            out_valid;
   logic            out_ready;
   logic [PP_W-1:0] aligned_pp_0, aligned_pp_1, aligned_pp_2;
   logic [PP_W-1:0] aligned_pp_3, aligned_pp_4, aligned_pp_5;
   logic [PP_W-1:0] aligned_pp_6, aligned_pp_7, aligned_pp_8;

   modport master (
      output in_valid, in_a, in_b, out_ready,
      input  in_ready, out_valid,
      input  aligned_pp_0, aligned_pp_1, aligned_pp_2, aligned_pp_3,
             aligned_pp_4, aligned_pp_5, aligned_pp_6, aligned_pp_7, aligned_pp_8
   );

   modport slave (
      input  in_valid, in_a, in_b, out_ready,
      output in_ready, out_valid,
      output aligned_pp_0, aligned_pp_1, aligned_pp_2, aligned_pp_3,
             aligned_pp_4, aligned_pp_5, aligned_pp_6, aligned_pp_7, aligned_pp_8
   );
endinterface

// File: rtl/sd4_digit_encoder.sv
// Radix-4 Booth digit from a 3-bit multiplier window {b[2i+1], b[2i], b[2i-1]}.
module sd4_digit_encoder
   import sd4_pkg::*;
(
   input  logic [DIGIT_W-1:0] win_i,
   output digit_t             digit_o
);

   // Window to signed digit; 000 and 111 both encode zero.
   always_comb begin
      digit_o = '0;
      case (win_i)
         3'b001, 3'b010: digit_o.one = 1'b1;
         3'b011:         digit_o.two = 1'b1;
         3'b100:         begin digit_o.neg = 1'b1; digit_o.two = 1'b1; end
         3'b101, 3'b110: begin digit_o.neg = 1'b1; digit_o.one = 1'b1; end
         default:        digit_o = '0;
      endcase
   end

endmodule

// File: rtl/sd4_pp_generator.sv
// SD4 partial-product generator: encodes one Booth digit per cycle into a
// bank of aligned partial-product registers, then holds them for the adder
// tree behind a valid/ready handshake.
// Optional build macro: SD4_ZERO_SKIP_EN -- skip GEN cycles for zero digits.
//
//   state | meaning
//   IDLE  | ready for a new operand pair
//   GEN   | writing pp[idx] for the current digit
//   HOLD  | all partial products valid, waiting for out_ready
module sd4_pp_generator
   import sd4_pkg::*;
#(
   parameter int A_W  = A_W_DEF,
   parameter int B_W  = B_W_DEF,
   parameter int PP_W = PP_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   sd4_pp_generator_if.slave bus
);

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [A_W-1:0]     a_q;
   logic [B_W-1:0]     b_q;
   logic [PP_W-1:0]    pp_q [NUM_PP];
   logic               accept;

   logic [B_W-1:0]     b_src;
   logic [B_W+2:0]     b_ext;
   digit_t             dig [NUM_PP];
   digit_t             cur;
   logic [PP_W-1:0]    a_ext, mag, sval, pp_val;

`ifdef SD4_ZERO_SKIP_EN
   // The search looks at the incoming operand while idle, the held one otherwise.
   assign b_src = (state_q == IDLE) ? bus.in_b : b_q;
`else
   assign b_src = b_q;
`endif
   assign b_ext = {2'b00, b_src, 1'b0};

   for (genvar g = 0; g < NUM_PP; g++) begin : g_enc
      sd4_digit_encoder u_enc (
         .win_i   (b_ext[2*g +: DIGIT_W]),
         .digit_o (dig[g])
      );
   end

   // Select the current digit and form its aligned partial product mod 2^PP_W.
   always_comb begin
      cur = '0;
      for (int i = 0; i < NUM_PP; i++)
         if (idx_q == IDX_W'(i)) cur = dig[i];
      a_ext  = {{(PP_W-A_W){a_q[A_W-1]}}, a_q};
      mag    = cur.two ? (a_ext << 1) : (cur.one ? a_ext : '0);
      sval   = cur.neg ? (~mag + 1'b1) : mag;
      pp_val = sval << {idx_q, 1'b0};
   end

`ifdef SD4_ZERO_SKIP_EN
   logic [IDX_W-1:0] first_idx, next_idx;
   logic             first_found, next_found;

   // Lowest non-zero digit overall, and lowest one above the current index.
   always_comb begin
      first_idx   = '0;
      first_found = 1'b0;
      next_idx    = '0;
      next_found  = 1'b0;
      for (int i = NUM_PP-1; i >= 0; i--) begin
         if (digit_nz(dig[i])) begin
            first_idx   = IDX_W'(i);
            first_found = 1'b1;
            if (IDX_W'(i) > idx_q) begin
               next_idx   = IDX_W'(i);
               next_found = 1'b1;
            end
         end
      end
   end
`endif

   // Next-state and digit-index sequencing.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      accept  = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               accept  = 1'b1;
               state_d = GEN;
               idx_d   = '0;
`ifdef SD4_ZERO_SKIP_EN
               if (first_found) idx_d = first_idx;
               else             state_d = HOLD;
`endif
            end
         end
         GEN: begin
`ifdef SD4_ZERO_SKIP_EN
            if (next_found) idx_d = next_idx;
            else            state_d = HOLD;
`else
            if (idx_q == IDX_W'(NUM_PP-1)) state_d = HOLD;
            else                           idx_d   = idx_q + 1'b1;
`endif
         end
         HOLD: begin
            if (bus.out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // FSM state and digit index registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

   // Operand capture and partial-product bank.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a_q <= '0;
         b_q <= '0;
         for (int i = 0; i < NUM_PP; i++) pp_q[i] <= '0;
      end else if (accept) begin
         a_q <= bus.in_a;
         b_q <= bus.in_b;
         for (int i = 0; i < NUM_PP; i++) pp_q[i] <= '0;
      end else if (state_q == GEN) begin
         for (int i = 0; i < NUM_PP; i++)
            if (idx_q == IDX_W'(i)) pp_q[i] <= pp_val;
      end
   end

   assign bus.in_ready     = (state_q == IDLE) && rst_n;
   assign bus.out_valid    = (state_q == HOLD);
   assign bus.aligned_pp_0 = pp_q[0];
   assign bus.aligned_pp_1 = pp_q[1];
   assign bus.aligned_pp_2 = pp_q[2];
   assign bus.aligned_pp_3 = pp_q[3];
   assign bus.aligned_pp_4 = pp_q[4];
   assign bus.aligned_pp_5 = pp_q[5];
   assign bus.aligned_pp_6 = pp_q[6];
   assign bus.aligned_pp_7 = pp_q[7];
   assign bus.aligned_pp_8 = pp_q[8];

endmodule

// File: tb/tb_sd4_pp_generator.sv
// Bench for sd4_pp_generator: directed and random operand pairs checked
// against an arithmetic Booth model; backpressure and reset-abort cases.
module tb_sd4_pp_generator;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   sd4_pp_generator_if #(.A_W(8), .B_W(16), .PP_W(16)) bus ();

   sd4_pp_generator #(.A_W(8), .B_W(16), .PP_W(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int bit_of(input logic [15:0] b, input int k);
      if (k < 0 || k > 15) return 0;
      return int'(b[k]);
   endfunction

   // Digit value straight from the radix-4 identity: -2*b[2i+1] + b[2i] + b[2i-1].
   function automatic int model_digit(input logic [15:0] b, input int i);
      return -2 * bit_of(b, 2*i+1) + bit_of(b, 2*i) + bit_of(b, 2*i-1);
   endfunction

   function automatic logic [15:0] model_pp(input logic [7:0] a, input logic [15:0] b, input int i);
      longint      prod;
      logic [63:0] p;
      prod = longint'(model_digit(b, i)) * longint'($signed(a)) * (longint'(1) << (2*i));
      p    = prod;
      return p[15:0];
   endfunction

   function automatic logic [15:0] model_product(input logic [7:0] a, input logic [15:0] b);
      longint      prod;
      logic [63:0] p;
      prod = longint'($signed(a)) * longint'(b);
      p    = prod;
      return p[15:0];
   endfunction

   function automatic int model_latency(input logic [15:0] b);
`ifdef SD4_ZERO_SKIP_EN
      int nz = 0;
      for (int i = 0; i < 9; i++) if (model_digit(b, i) != 0) nz++;
      return 1 + nz;
`else
      return 10;
`endif
   endfunction

   function automatic logic [15:0] obs_pp(input int i);
      case (i)
         0: return bus.aligned_pp_0;
         1: return bus.aligned_pp_1;
         2: return bus.aligned_pp_2;
         3: return bus.aligned_pp_3;
         4: return bus.aligned_pp_4;
         5: return bus.aligned_pp_5;
         6: return bus.aligned_pp_6;
         7: return bus.aligned_pp_7;
         default: return bus.aligned_pp_8;
      endcase
   endfunction

   task automatic check_pps(input string tag, input logic [7:0] a, input logic [15:0] b);
      logic [15:0] sum;
      sum = '0;
      for (int i = 0; i < 9; i++) begin
         chk($sformatf("%s_pp%0d a=%0h b=%0h", tag, i, a, b), 32'(obs_pp(i)), 32'(model_pp(a, b, i)));
         sum = sum + obs_pp(i);
      end
      chk($sformatf("%s_sum a=%0h b=%0h", tag, a, b), 32'(sum), 32'(model_product(a, b)));
   endtask

   task automatic check_zero_pps(input string tag);
      for (int i = 0; i < 9; i++)
         chk($sformatf("%s_pp%0d", tag, i), 32'(obs_pp(i)), 32'h0);
   endtask

   // Accept one pair, measure latency, check results; bp=1 adds 5 cycles of
   // backpressure with a spurious in_valid pulse before releasing out_ready.
   task automatic run_op(input logic [7:0] a, input logic [15:0] b, input bit bp);
      int n;
      @(negedge clk);
      chk("in_ready_idle", 32'(bus.in_ready), 32'h1);
      bus.in_valid  = 1'b1;
      bus.in_a      = a;
      bus.in_b      = b;
      bus.out_ready = !bp;
      @(negedge clk);
      bus.in_valid = 1'b0;
      n = 1;
      while (!bus.out_valid && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk($sformatf("latency b=%0h", b), 32'(n), 32'(model_latency(b)));
      chk("in_ready_hold", 32'(bus.in_ready), 32'h0);
      check_pps("op", a, b);
      if (bp) begin
         for (int c = 0; c < 5; c++) begin
            bus.in_valid = (c == 2);
            bus.in_a     = ~a;
            bus.in_b     = ~b;
            @(negedge clk);
            chk("bp_out_valid", 32'(bus.out_valid), 32'h1);
            chk("bp_in_ready", 32'(bus.in_ready), 32'h0);
            chk("bp_pp0_stable", 32'(bus.aligned_pp_0), 32'(model_pp(a, b, 0)));
            chk("bp_pp1_stable", 32'(bus.aligned_pp_1), 32'(model_pp(a, b, 1)));
         end
         bus.in_valid = 1'b0;
         check_pps("bp_end", a, b);
         bus.out_ready = 1'b1;
      end
      @(negedge clk);
      chk("release_out_valid", 32'(bus.out_valid), 32'h0);
      chk("release_in_ready", 32'(bus.in_ready), 32'h1);
      chk("release_pp_kept", 32'(bus.aligned_pp_1), 32'(model_pp(a, b, 1)));
      bus.out_ready = 1'b0;
   endtask

   // Pull rst_n low for one cycle either in the 4th GEN cycle or in HOLD.
   task automatic reset_abort(input logic [7:0] a, input logic [15:0] b, input bit in_hold);
      int n;
      @(negedge clk);
      bus.in_valid  = 1'b1;
      bus.in_a      = a;
      bus.in_b      = b;
      bus.out_ready = 1'b0;
      @(negedge clk);
      bus.in_valid = 1'b0;
      if (in_hold) begin
         n = 1;
         while (!bus.out_valid && n < 40) begin
            @(negedge clk);
            n++;
         end
         chk("abort_reached_hold", 32'(bus.out_valid), 32'h1);
      end else begin
         repeat (3) @(negedge clk);
      end
      chk("abort_pp0_written", 32'(bus.aligned_pp_0), 32'(model_pp(a, b, 0)));
      rst_n = 1'b0;
      #1;
      chk("abort_in_ready_rst", 32'(bus.in_ready), 32'h0);
      @(negedge clk);
      chk("abort_out_valid", 32'(bus.out_valid), 32'h0);
      chk("abort_in_ready_low", 32'(bus.in_ready), 32'h0);
      check_zero_pps("abort");
      rst_n = 1'b1;
      #1;
      chk("abort_in_ready_back", 32'(bus.in_ready), 32'h1);
   endtask

   initial begin
      checks        = 0;
      errors        = 0;
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_a      = '0;
      bus.in_b      = '0;
      bus.out_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_in_ready", 32'(bus.in_ready), 32'h0);
      chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
      check_zero_pps("rst");
      rst_n = 1'b1;
      #1;
      chk("rst_release_in_ready", 32'(bus.in_ready), 32'h1);

      // out_ready while idle must not disturb anything
      bus.out_ready = 1'b1;
      repeat (2) @(negedge clk);
      chk("idle_out_ready_valid", 32'(bus.out_valid), 32'h0);
      chk("idle_out_ready_ready", 32'(bus.in_ready), 32'h1);
      bus.out_ready = 1'b0;

      run_op(8'h03, 16'h0005, 1'b0);
      chk("tp1_pp1", 32'(bus.aligned_pp_1), 32'h000C);
      run_op(8'hFF, 16'hFFFF, 1'b0);
      chk("tp2_pp0", 32'(bus.aligned_pp_0), 32'h0001);
      run_op(8'h80, 16'h0006, 1'b0);
      chk("tp3_pp1", 32'(bus.aligned_pp_1), 32'hFC00);
      run_op(8'h5A, 16'h0000, 1'b0);
      run_op(8'h80, 16'hAAAA, 1'b0);
      run_op(8'h7F, 16'h8000, 1'b0);
      run_op(8'h03, 16'h0005, 1'b1);

      reset_abort(8'h03, 16'h5555, 1'b0);
      reset_abort(8'hC3, 16'h1234, 1'b1);

      for (int k = 0; k < 30; k++)
         run_op(8'($urandom), 16'($urandom), bit'($urandom_range(0, 3) == 0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
